// File: rtl/writeback_unit.sv
// Registered writeback stage: picks ALU/link/immediate/load data and drives the
// register-file write port, waiting up to MAX_WAIT cycles for load data.
module writeback_unit #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [1:0]      wb_sel,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lsb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            rf_wr_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wr_data,
    output logic            stall,
    output logic            ld_timeout,
    output logic            ld_misalign
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LINK = 2'd1;
    localparam logic [1:0] SEL_IMM  = 2'd2;
    localparam logic [1:0] SEL_LOAD = 2'd3;
    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] lsb);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~lsb[0];
            3'b010:         ok = (lsb == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lsb,
                                                 input logic [XLEN-1:0] d);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = d[{lsb, 3'b000} +: 8];
        h = d[{lsb[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            3'b010:  r = d;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [0:0]      state_r, state_n;
    logic [7:0]      cnt_r, cnt_n;
    logic [4:0]      ld_rd_r, ld_rd_n;
    logic [2:0]      ld_f3_r, ld_f3_n;
    logic [1:0]      ld_lsb_r, ld_lsb_n;
    logic            wr_s;
    logic            commit_s;
    logic [4:0]      wr_rd_s;
    logic [XLEN-1:0] wr_data_s;
    logic            timeout_n, misalign_n;

    assign wb_ready = (state_r == ST_IDLE);
    assign stall    = (state_r == ST_WAIT);

    // Next-state, write-selection and sticky-flag logic.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        ld_rd_n    = ld_rd_r;
        ld_f3_n    = ld_f3_r;
        ld_lsb_n   = ld_lsb_r;
        wr_s       = 1'b0;
        wr_rd_s    = 5'd0;
        wr_data_s  = '0;
        timeout_n  = ld_timeout;
        misalign_n = ld_misalign;
        case (state_r)
            ST_IDLE: begin
                if (wb_valid) begin
                    case (wb_sel)
                        SEL_ALU: begin
                            wr_s      = 1'b1;
                            wr_rd_s   = wb_rd;
                            wr_data_s = alu_result;
                        end
                        SEL_LINK: begin
                            wr_s      = 1'b1;
                            wr_rd_s   = wb_rd;
                            wr_data_s = pc + XLEN'(32'd4);
                        end
                        SEL_IMM: begin
                            wr_s      = 1'b1;
                            wr_rd_s   = wb_rd;
                            wr_data_s = imm;
                        end
                        SEL_LOAD: begin
                            if (!load_legal(ld_funct3, ld_addr_lsb)) begin
                                misalign_n = 1'b1;
                            end else if (mem_rvalid) begin
                                wr_s      = 1'b1;
                                wr_rd_s   = wb_rd;
                                wr_data_s = fmt_load(ld_funct3, ld_addr_lsb, mem_rdata);
                            end else begin
                                state_n  = ST_WAIT;
                                cnt_n    = 8'd0;
                                ld_rd_n  = wb_rd;
                                ld_f3_n  = ld_funct3;
                                ld_lsb_n = ld_addr_lsb;
                            end
                        end
                        default: wr_s = 1'b0;
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Data arriving on the final wait cycle still wins over the timeout.
                if (mem_rvalid) begin
                    wr_s      = 1'b1;
                    wr_rd_s   = ld_rd_r;
                    wr_data_s = fmt_load(ld_f3_r, ld_lsb_r, mem_rdata);
                    state_n   = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    cnt_n = cnt_r + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        commit_s = wr_s && (wr_rd_s != 5'd0);
    end

    // State and registered outputs; x0 writes are dropped entirely.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            ld_rd_r     <= 5'd0;
            ld_f3_r     <= 3'd0;
            ld_lsb_r    <= 2'd0;
            rf_wr_en    <= 1'b0;
            rf_rd       <= 5'd0;
            rf_wr_data  <= '0;
            ld_timeout  <= 1'b0;
            ld_misalign <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            ld_rd_r     <= ld_rd_n;
            ld_f3_r     <= ld_f3_n;
            ld_lsb_r    <= ld_lsb_n;
            rf_wr_en    <= commit_s;
            ld_timeout  <= timeout_n;
            ld_misalign <= misalign_n;
            if (commit_s) begin
                rf_rd      <= wr_rd_s;
                rf_wr_data <= wr_data_s;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writes, a
// negedge monitor pops and compares every rf_wr_en pulse.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd;
    logic [31:0] alu_result, pc, imm, mem_rdata;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lsb;
    logic        mem_rvalid;
    logic        rf_wr_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wr_data;
    logic        stall, ld_timeout, ld_misalign;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    writeback_unit #(.XLEN(32), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_sel(wb_sel), .wb_rd(wb_rd), .alu_result(alu_result), .pc(pc), .imm(imm),
        .ld_funct3(ld_funct3), .ld_addr_lsb(ld_addr_lsb), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .rf_wr_en(rf_wr_en), .rf_rd(rf_rd),
        .rf_wr_data(rf_wr_data), .stall(stall), .ld_timeout(ld_timeout),
        .ld_misalign(ld_misalign)
    );

    always #5 clk = ~clk;

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, none expected", rf_rd, rf_wr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_rd, rf_wr_data} !== e) begin
                    bad++;
                    $display("FAIL write_data: got rd=%0d data=%h, want rd=%0d data=%h",
                             rf_rd, rf_wr_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                         input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] rdata,
                         input logic rv);
        wb_valid    = 1'b1;
        wb_sel      = sel;
        wb_rd       = rd;
        alu_result  = val;
        pc          = val;
        imm         = val;
        ld_funct3   = f3;
        ld_addr_lsb = lsb;
        mem_rdata   = rdata;
        mem_rvalid  = rv;
    endtask

    task automatic quiet();
        wb_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Same-cycle load vectors: funct3, lsb, rd, expected data.
    logic [2:0]  lv_f3  [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
    logic [1:0]  lv_lsb [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    logic [4:0]  lv_rd  [4] = '{5'd3, 5'd4, 5'd6, 5'd7};
    logic [31:0] lv_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0080, 32'hFFFF_FF11};

    initial begin
        reset = 1'b0;
        drive(2'd0, 5'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0);
        quiet();
        step();
        step();
        reset = 1'b1;
        check("rst_ready", {31'd0, wb_ready}, 32'd1);
        check("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("rst_rd", {27'd0, rf_rd}, 32'd0);
        check("rst_data", rf_wr_data, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_flags", {30'd0, ld_timeout, ld_misalign}, 32'd0);

        // ALU write, one-cycle latency, single-cycle pulse.
        drive(2'd0, 5'd5, 32'h0000_1234, 3'd0, 2'd0, 32'd0, 1'b0);
        exp_q.push_back({5'd5, 32'h0000_1234});
        step();
        quiet();
        check("alu_latency", {31'd0, rf_wr_en}, 32'd1);
        step();
        check("alu_pulse", {31'd0, rf_wr_en}, 32'd0);
        check("alu_hold", rf_wr_data, 32'h0000_1234);

        // Back-to-back LINK writes, including the wrap.
        drive(2'd1, 5'd1, 32'hFFFF_FFFC, 3'd0, 2'd0, 32'd0, 1'b0);
        exp_q.push_back({5'd1, 32'h0000_0000});
        step();
        drive(2'd1, 5'd2, 32'h0000_0100, 3'd0, 2'd0, 32'd0, 1'b0);
        exp_q.push_back({5'd2, 32'h0000_0104});
        step();
        drive(2'd2, 5'd15, 32'hA5A5_0001, 3'd0, 2'd0, 32'd0, 1'b0);
        exp_q.push_back({5'd15, 32'hA5A5_0001});
        step();

        // Loads with same-cycle data.
        for (int i = 0; i < 4; i++) begin
            drive(2'd3, lv_rd[i], 32'd0, lv_f3[i], lv_lsb[i], 32'h0080_FF11, 1'b1);
            exp_q.push_back({lv_rd[i], lv_exp[i]});
            step();
        end
        quiet();
        step();

        // LW with data three cycles later; an ALU request waits out the stall.
        drive(2'd3, 5'd8, 32'd0, 3'b010, 2'd0, 32'd0, 1'b0);
        step();
        drive(2'd0, 5'd9, 32'h0000_AAAA, 3'd0, 2'd0, 32'hDEAD_BEEF, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            check("wait_stall", {31'd0, stall}, 32'd1);
            check("wait_ready", {31'd0, wb_ready}, 32'd0);
            check("wait_no_wr", {31'd0, rf_wr_en}, 32'd0);
            if (c < 3) step();
        end
        mem_rvalid = 1'b1;
        exp_q.push_back({5'd8, 32'hDEAD_BEEF});
        step();
        mem_rvalid = 1'b0;
        check("lw_wr_cycle4", {31'd0, rf_wr_en}, 32'd1);
        check("lw_ready_back", {31'd0, wb_ready}, 32'd1);
        exp_q.push_back({5'd9, 32'h0000_AAAA});
        step();
        quiet();
        check("held_alu_wr", {31'd0, rf_wr_en}, 32'd1);
        step();

        // Timeout after MAX_WAIT cycles without data.
        drive(2'd3, 5'd10, 32'd0, 3'b010, 2'd0, 32'd0, 1'b0);
        step();
        quiet();
        for (int c = 0; c < 8; c++) begin
            check("to_not_yet", {31'd0, ld_timeout}, 32'd0);
            check("to_stall", {31'd0, stall}, 32'd1);
            step();
        end
        check("to_set", {31'd0, ld_timeout}, 32'd1);
        check("to_ready", {31'd0, wb_ready}, 32'd1);
        check("to_no_wr", {31'd0, rf_wr_en}, 32'd0);

        drive(2'd3, 5'd11, 32'd0, 3'b010, 2'd0, 32'h1234_5678, 1'b1);
        exp_q.push_back({5'd11, 32'h1234_5678});
        step();
        quiet();
        check("to_sticky", {31'd0, ld_timeout}, 32'd1);

        // Misaligned LW and an x0 write.
        drive(2'd3, 5'd13, 32'd0, 3'b010, 2'd1, 32'hFFFF_FFFF, 1'b1);
        step();
        quiet();
        check("misalign_set", {31'd0, ld_misalign}, 32'd1);
        check("misalign_no_wr", {31'd0, rf_wr_en}, 32'd0);
        check("misalign_ready", {31'd0, wb_ready}, 32'd1);
        drive(2'd0, 5'd0, 32'h0000_0055, 3'd0, 2'd0, 32'd0, 1'b0);
        step();
        quiet();
        check("x0_no_wr", {31'd0, rf_wr_en}, 32'd0);
        check("x0_data_hold", rf_wr_data, 32'h1234_5678);

        // Reset during WAIT_LD aborts the load and clears flags.
        drive(2'd3, 5'd14, 32'd0, 3'b010, 2'd0, 32'h7777_7777, 1'b0);
        step();
        quiet();
        check("rstw_stall", {31'd0, stall}, 32'd1);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        step();
        reset      = 1'b1;
        mem_rvalid = 1'b0;
        check("rstw_idle", {31'd0, wb_ready}, 32'd1);
        check("rstw_no_wr", {31'd0, rf_wr_en}, 32'd0);
        check("rstw_flags", {30'd0, ld_timeout, ld_misalign}, 32'd0);
        step();
        check("rstw_still_no_wr", {31'd0, rf_wr_en}, 32'd0);

        // Data on the last wait cycle wins over the timeout.
        drive(2'd3, 5'd12, 32'd0, 3'b101, 2'd2, 32'hCAFE_F00D, 1'b0);
        step();
        quiet();
        for (int c = 0; c < 7; c++) step();
        mem_rvalid = 1'b1;
        exp_q.push_back({5'd12, 32'h0000_CAFE});
        step();
        mem_rvalid = 1'b0;
        check("edge_wr", {31'd0, rf_wr_en}, 32'd1);
        check("edge_no_to", {31'd0, ld_timeout}, 32'd0);
        step();
        step();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Registered, parametrised writeback stage that selects the register-file write value (ALU result, link address, immediate, or aligned load data) and drives the register-file write port one cycle after acceptance. It sits between the ALU/Decoder/DataMemory and RegisterFile, replacing the combinational wr_data_mux. New relative to that mux:
- PC+4 link generation.
- Byte/halfword load extraction with sign/zero extension.
- Multi-cycle load wait with timeout.
- Misalignment detection.
- x0 write suppression.

## Interface
Parameters:
- XLEN, 32, datapath width (≥16, multiple of 8).
- MAX_WAIT, 8, maximum load-wait cycles before timeout (1..255).

Ports (one clock; reset is synchronous, active-low, and is the only reset):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset. 0 at a rising edge = reset.
- wb_valid  in  1  writeback request this cycle.
- wb_ready  out  1  unit can accept. High exactly in IDLE.
- wb_sel  in  2  source select: 0=ALU, 1=LINK, 2=IMM, 3=LOAD.
- wb_rd  in  5  destination register.
- alu_result  in  XLEN  ALU output.
- pc  in  XLEN  instruction address. Link value = pc+4.
- imm  in  XLEN  decoded immediate.
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Others are illegal.
- ld_addr_lsb  in  2  low bits of the load address.
- mem_rdata  in  XLEN  word-aligned memory read data.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- rf_wr_en  out  1  register-file write strobe.
- rf_rd  out  5  write address.
- rf_wr_data  out  XLEN  write data.
- stall  out  1  waiting for load data.
- ld_timeout  out  1  sticky: a load exceeded MAX_WAIT.
- ld_misalign  out  1  sticky: misaligned or illegal load.

## Operation
- Accept = wb_valid && wb_ready at a rising edge. All wb_*, ld_*, pc, imm and alu_result are sampled only at accept.
- FSM states: IDLE and WAIT_LD.
- IDLE with non-LOAD accept:
  - ALU → alu_result; LINK → pc+4 (mod 2^XLEN, wraps); IMM → imm.
  - Next cycle: rf_wr_en=1 with the registered rd/data. State stays IDLE, so back-to-back accepts are allowed.
- IDLE with LOAD accept, legality check first:
  - LH/LHU require lsb[0]=0. LW requires lsb=00. funct3 must be a legal code.
  - Failure: set ld_misalign, no write, stay IDLE.
- IDLE with legal LOAD accept:
  - mem_rvalid=1 in the same cycle: complete as a non-LOAD accept.
  - Otherwise: latch rd, funct3 and lsb; enter WAIT_LD; clear wait counter.
- WAIT_LD:
  - stall=1, wb_ready=0. Counter increments each cycle without mem_rvalid.
  - mem_rvalid=1: format data, rf_wr_en=1 next cycle, return to IDLE.
  - Counter reaches MAX_WAIT with no rvalid: set ld_timeout, no write, return to IDLE.
  - mem_rvalid arriving in the same cycle as the counter reaching MAX_WAIT counts as data arriving, not a timeout.
- Load formatting:
  - Byte = mem_rdata[8*lsb +: 8]. Half = mem_rdata[16*lsb[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- wb_rd=0: the full sequence runs (including the load wait), but rf_wr_en stays 0.
- ld_timeout and ld_misalign clear only on reset.

## Timing
- Reset values (reset=0 at an edge):
  - State IDLE; wb_ready=1; rf_wr_en=0; rf_rd=0; rf_wr_data=0; stall=0; ld_timeout=0; ld_misalign=0; counter=0.
- Reset in WAIT_LD aborts the load: no write, IDLE next cycle.
- Output latency:
  - Non-LOAD, or LOAD with same-cycle rvalid: 1 cycle from accept to rf_wr_en.
  - Load with rvalid N cycles after accept: rf_wr_en at cycle N+1.
  - Timeout: flag set N=MAX_WAIT cycles after accept.
- rf_wr_en is a single-cycle pulse. rf_rd/rf_wr_data hold their value until the next write.
- wb_ready, stall: combinational from state only, never from inputs.
- mem_rvalid is ignored in IDLE unless a LOAD is being accepted that cycle.

## Test plan
- Reset, then ALU accept with alu_result=0x0000_1234, rd=5 → rf_wr_en=1 one cycle later, rf_rd=5, rf_wr_data=0x1234; next cycle rf_wr_en=0.
- LINK with pc=0xFFFF_FFFC, rd=1 → rf_wr_data=0x0000_0000 (wrap); with pc=0x100 → 0x104.
- LB with lsb=2, mem_rdata=0x0080_FF11, same-cycle rvalid → data=0xFFFF_FF80. Repeat as LBU → 0x0000_0080. LHU with lsb=2 → 0x0000_0080. LH with lsb=0 → 0xFFFF_FF11.
- LW, rvalid 3 cycles after accept → stall and wb_ready=0 for 3 cycles; rf_wr_en at cycle 4; a wb_valid held during the stall is accepted only once IDLE.
- LW with MAX_WAIT=8 and no rvalid → ld_timeout=1 at cycle 8, no write, wb_ready=1. A second load then completes normally and ld_timeout stays 1.
- LW with lsb=01 → ld_misalign=1, no write. ALU write with rd=0 → rf_wr_en=0. Reset asserted mid-WAIT_LD → IDLE and no write; reset clears both sticky flags.
